traffic_light_monitor: RTL and testbench

//  Receiving end of the traffic-light controller interface: samples the controller's count/gyr outputs.

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/seg7_decoder.sv | 36 +++
 rtl/traffic_light_monitor.sv | 279 +++++++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : traffic_pkg
// Purpose : Phase, state, fault-code and 7-segment definitions shared by the
//           traffic-light monitor and its digit decoder.
// Rev     : 1.0  initial release
// ============================================================================
package traffic_pkg;

  localparam logic [1:0] PH_GREEN  = 2'd0;
  localparam logic [1:0] PH_YELLOW = 2'd1;
  localparam logic [1:0] PH_RED    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_GYR  = 2'd1;
  localparam logic [1:0] FLT_SEQ  = 2'd2;
  localparam logic [1:0] FLT_CNT  = 2'd3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIGIT_E = 4'hE;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_GREEN:  nxt = PH_YELLOW;
      PH_YELLOW: nxt = PH_RED;
      default:   nxt = PH_GREEN;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg7_decoder
// Purpose : Combinational digit-to-7-segment decoder; 0-9 and E, else blank.
// Rev     : 1.0  initial release
// ============================================================================
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        DIGIT_E: seg = SEG_E;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module  : traffic_light_monitor
// Purpose : Checks the controller's phase/countdown stream, drives lamps and
//           a two-digit countdown, and latches faults into a blinking display.
// Rev     : 1.0  initial release
// ============================================================================
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int G_MAX     = 16,
  parameter int Y_MAX     = 6,
  parameter int R_MAX     = 11,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  input  logic [2:0] gyr,
  input  logic       clr_fault,
  output logic       lamp_g,
  output logic       lamp_y,
  output logic       lamp_r,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] cycle_cnt
);

  localparam logic [4:0] C_G_LIM      = 5'(G_MAX);
  localparam logic [4:0] C_Y_LIM      = 5'(Y_MAX);
  localparam logic [4:0] C_R_LIM      = 5'(R_MAX);
  localparam logic [4:0] C_TIMER_SAT  = 5'h1F;
  localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_DIV - 1);
  localparam logic [7:0] C_CYCLE_SAT  = 8'hFF;

  // Input sample stage
  logic [3:0] s_count_d, s_count_q;
  logic [2:0] s_gyr_d,   s_gyr_q;
  logic       s_clr_d,   s_clr_q;
  logic       s_valid_d, s_valid_q;

  // Monitor state
  state_e     state_d,      state_q;
  logic [1:0] phase_d,      phase_q;
  logic [3:0] prev_count_d, prev_count_q;
  logic [4:0] timer_d,      timer_q;
  logic [1:0] code_d,       code_q;
  logic [7:0] cycle_cnt_d,  cycle_cnt_q;
  logic [7:0] blink_cnt_d,  blink_cnt_q;
  logic       blink_d,      blink_q;

  // Registered outputs
  logic       lamp_g_d,   lamp_g_q;
  logic       lamp_y_d,   lamp_y_q;
  logic       lamp_r_d,   lamp_r_q;
  logic [6:0] seg_tens_d, seg_tens_q;
  logic [6:0] seg_ones_d, seg_ones_q;
  logic       fault_d,    fault_q;

  logic       gyr_bad;
  logic [1:0] s_phase;
  logic [3:0] exp_count;
  logic [4:0] timer_lim;
  logic       viol;
  logic [1:0] viol_code;

  logic [3:0] tens_digit, ones_digit;
  logic       tens_blank, ones_blank;

  always_comb begin
    s_count_d = count;
    s_gyr_d   = gyr;
    s_clr_d   = clr_fault;
    s_valid_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    s_count_q <= s_count_d;
    s_gyr_q   <= s_gyr_d;
    s_clr_q   <= s_clr_d;
  end

  assign gyr_bad   = (s_gyr_q > 3'd2);
  assign s_phase   = s_gyr_q[1:0];
  assign exp_count = prev_count_q - 4'd1;

  always_comb begin
    case (phase_q)
      PH_GREEN:  timer_lim = C_G_LIM;
      PH_YELLOW: timer_lim = C_Y_LIM;
      default:   timer_lim = C_R_LIM;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    prev_count_d = prev_count_q;
    timer_d      = timer_q;
    code_d       = code_q;
    cycle_cnt_d  = cycle_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    blink_d      = blink_q;
    viol         = 1'b0;
    viol_code    = FLT_NONE;

    case (state_q)
      IDLE: begin
        if (s_valid_q) begin
          if (gyr_bad) begin
            viol      = 1'b1;
            viol_code = FLT_GYR;
          end else begin
            state_d      = RUN;
            phase_d      = s_phase;
            prev_count_d = s_count_q;
            timer_d      = 5'd1;
          end
        end
      end

      RUN: begin
        if (gyr_bad) begin
          viol      = 1'b1;
          viol_code = FLT_GYR;
        end else if (s_phase != phase_q) begin
          if (s_phase != next_phase(phase_q)) begin
            viol      = 1'b1;
            viol_code = FLT_SEQ;
          end else begin
            phase_d      = s_phase;
            prev_count_d = s_count_q;
            timer_d      = 5'd1;
            if (phase_q == PH_RED && cycle_cnt_q != C_CYCLE_SAT) begin
              cycle_cnt_d = cycle_cnt_q + 8'd1;
            end
          end
        end else if (s_count_q != exp_count) begin
          viol      = 1'b1;
          viol_code = FLT_CNT;
        end else if (timer_q >= timer_lim) begin
          viol      = 1'b1;
          viol_code = FLT_CNT;
        end else begin
          prev_count_d = s_count_q;
          if (timer_q != C_TIMER_SAT) begin
            timer_d = timer_q + 5'd1;
          end
        end
      end

      FAULT: begin
        // Only a clear is acted on here; a bad encoding in the same sample re-latches
        if (s_clr_q) begin
          if (gyr_bad) begin
            viol      = 1'b1;
            viol_code = FLT_GYR;
          end else begin
            state_d = IDLE;
            code_d  = FLT_NONE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (viol) begin
      state_d     = FAULT;
      code_d      = viol_code;
      blink_cnt_d = 8'd0;
      blink_d     = 1'b1;
    end else if (state_q == FAULT && state_d == FAULT) begin
      if (blink_cnt_q == C_BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    lamp_g_d   = 1'b0;
    lamp_y_d   = 1'b0;
    lamp_r_d   = 1'b0;
    fault_d    = 1'b0;
    tens_digit = 4'd0;
    ones_digit = 4'd0;
    tens_blank = 1'b1;
    ones_blank = 1'b1;

    case (state_d)
      RUN: begin
        lamp_g_d   = (s_phase == PH_GREEN);
        lamp_y_d   = (s_phase == PH_YELLOW);
        lamp_r_d   = (s_phase == PH_RED);
        ones_blank = 1'b0;
        if (s_count_q >= 4'd10) begin
          tens_digit = 4'd1;
          tens_blank = 1'b0;
          ones_digit = s_count_q - 4'd10;
        end else begin
          ones_digit = s_count_q;
        end
      end
      FAULT: begin
        lamp_y_d   = blink_d;
        fault_d    = 1'b1;
        tens_digit = DIGIT_E;
        tens_blank = 1'b0;
        ones_digit = {2'b00, code_d};
        ones_blank = 1'b0;
      end
      default: ;
    endcase
  end

  seg7_decoder u_seg_tens (
    .digit (tens_digit),
    .blank (tens_blank),
    .seg   (seg_tens_d)
  );

  seg7_decoder u_seg_ones (
    .digit (ones_digit),
    .blank (ones_blank),
    .seg   (seg_ones_d)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_valid_q    <= 1'b0;
      state_q      <= IDLE;
      phase_q      <= PH_GREEN;
      prev_count_q <= 4'd0;
      timer_q      <= 5'd0;
      code_q       <= FLT_NONE;
      cycle_cnt_q  <= 8'd0;
      blink_cnt_q  <= 8'd0;
      blink_q      <= 1'b0;
      lamp_g_q     <= 1'b0;
      lamp_y_q     <= 1'b0;
      lamp_r_q     <= 1'b0;
      seg_tens_q   <= SEG_BLANK;
      seg_ones_q   <= SEG_BLANK;
      fault_q      <= 1'b0;
    end else begin
      s_valid_q    <= s_valid_d;
      state_q      <= state_d;
      phase_q      <= phase_d;
      prev_count_q <= prev_count_d;
      timer_q      <= timer_d;
      code_q       <= code_d;
      cycle_cnt_q  <= cycle_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      lamp_g_q     <= lamp_g_d;
      lamp_y_q     <= lamp_y_d;
      lamp_r_q     <= lamp_r_d;
      seg_tens_q   <= seg_tens_d;
      seg_ones_q   <= seg_ones_d;
      fault_q      <= fault_d;
    end
  end

  assign lamp_g     = lamp_g_q;
  assign lamp_y     = lamp_y_q;
  assign lamp_r     = lamp_r_q;
  assign seg_tens   = seg_tens_q;
  assign seg_ones   = seg_ones_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_traffic_light_monitor
// Purpose : Directed scenarios plus random controller traffic against a
//           sample-level behavioural model of the monitor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;

  localparam int G_MAX     = 16;
  localparam int Y_MAX     = 6;
  localparam int R_MAX     = 11;
  localparam int BLINK_DIV = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] count = 4'd0;
  logic [2:0] gyr = 3'd0;
  logic       clr_fault = 1'b0;
  logic       lamp_g, lamp_y, lamp_r, fault;
  logic [6:0] seg_tens, seg_ones;
  logic [1:0] fault_code;
  logic [7:0] cycle_cnt;

  traffic_light_monitor #(
    .G_MAX(G_MAX), .Y_MAX(Y_MAX), .R_MAX(R_MAX), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .count(count), .gyr(gyr), .clr_fault(clr_fault),
    .lamp_g(lamp_g), .lamp_y(lamp_y), .lamp_r(lamp_r),
    .seg_tens(seg_tens), .seg_ones(seg_ones),
    .fault(fault), .fault_code(fault_code), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Lit segments (active-high gfedcba) for 0-9 and E; the display shows the complement
  logic [6:0] seg_on [0:10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h79};

  function automatic logic [6:0] glyph(input int d);
    return ~seg_on[d];
  endfunction

  function automatic int phase_limit(input int ph);
    if (ph == 0) return G_MAX;
    if (ph == 1) return Y_MAX;
    return R_MAX;
  endfunction

  // Reference model: mode 0 idle, 1 run, 2 fault; one controller sample per clock
  int  m_mode = 0, m_phase = 0, m_prev = 0, m_n = 0, m_code = 0, m_cycles = 0, m_age = 0;
  int  m_sc = 0, m_sg = 0;
  bit  m_sclr = 1'b0, m_sv = 1'b0;
  logic       e_g, e_y, e_r, e_fault;
  logic [6:0] e_tens, e_ones;

  task automatic model_edge(input bit rst_n, input int c, input int g, input bit clr);
    bit bad;
    int bc;
    bad = 1'b0;
    bc  = 0;
    if (!rst_n) begin
      m_mode   = 0;
      m_code   = 0;
      m_cycles = 0;
    end else if (m_sv) begin
      if (m_mode == 0) begin
        if (m_sg >= 3) begin bad = 1'b1; bc = 1; end
        else begin m_mode = 1; m_phase = m_sg; m_prev = m_sc; m_n = 1; end
      end else if (m_mode == 1) begin
        if (m_sg >= 3) begin bad = 1'b1; bc = 1; end
        else if (m_sg != m_phase) begin
          if (m_sg != (m_phase + 1) % 3) begin bad = 1'b1; bc = 2; end
          else begin
            if (m_phase == 2 && m_cycles < 255) m_cycles++;
            m_phase = m_sg; m_prev = m_sc; m_n = 1;
          end
        end
        else if (m_sc != (m_prev + 15) % 16) begin bad = 1'b1; bc = 3; end
        else if (m_n >= phase_limit(m_phase)) begin bad = 1'b1; bc = 3; end
        else begin m_prev = m_sc; m_n++; end
      end else begin
        if (m_sclr) begin
          if (m_sg >= 3) begin bad = 1'b1; bc = 1; end
          else begin m_mode = 0; m_code = 0; end
        end else begin
          m_age++;
        end
      end
      if (bad) begin m_mode = 2; m_code = bc; m_age = 0; end
    end
    m_sc = c; m_sg = g; m_sclr = clr; m_sv = rst_n;

    e_g = 1'b0; e_y = 1'b0; e_r = 1'b0; e_fault = 1'b0;
    e_tens = 7'h7F; e_ones = 7'h7F;
    if (m_mode == 1) begin
      e_g = (m_phase == 0); e_y = (m_phase == 1); e_r = (m_phase == 2);
      if (m_prev >= 10) e_tens = glyph(1);
      e_ones = glyph(m_prev % 10);
    end else if (m_mode == 2) begin
      e_y = ((m_age / BLINK_DIV) % 2 == 0);
      e_fault = 1'b1;
      e_tens = glyph(10);
      e_ones = glyph(m_code);
    end
  endtask

  task automatic step(input bit rst_n, input int c, input int g, input bit clr);
    reset = rst_n; count = c[3:0]; gyr = g[2:0]; clr_fault = clr;
    @(posedge clk);
    model_edge(rst_n, c, g, clr);
    #1;
    check("lamps_fault", 32'({fault, fault_code, lamp_g, lamp_y, lamp_r}),
          32'({e_fault, 2'(m_code), e_g, e_y, e_r}));
    check("segments", 32'({seg_tens, seg_ones}), 32'({e_tens, e_ones}));
    check("cycle_cnt", 32'(cycle_cnt), 32'(m_cycles));
  endtask

  task automatic run_phase(input int g, input int from, input int downto);
    for (int k = from; k >= downto; k--) step(1'b1, k, g, 1'b0);
  endtask

  int rph, rc, rcv, rgv, rsel;
  bit rclr, rrst;

  initial begin
    // Reset state
    step(1'b0, 0, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    check("rst_outs", 32'({fault, fault_code, lamp_g, lamp_y, lamp_r, cycle_cnt}), 32'd0);
    check("rst_segs", 32'({seg_tens, seg_ones}), 32'h3FFF);

    // Legal cycle G,Y,R,G
    run_phase(0, 15, 0);
    run_phase(1, 5, 0);
    run_phase(2, 10, 0);
    run_phase(0, 15, 13);
    check("t1_cycle", 32'(cycle_cnt), 32'd1);
    check("t1_fault", 32'(fault), 32'd0);

    // Illegal encoding in RUN
    run_phase(0, 12, 10);
    step(1'b1, 9, 3, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 8, 0, 1'b0);
    check("t2_code", 32'(fault_code), 32'd1);
    check("t2_segs", 32'({seg_tens, seg_ones}), 32'({7'h06, 7'h79}));
    for (int k = 0; k < 20; k++) step(1'b1, 8, 0, 1'b0);

    // Clear with a legal sample: IDLE then RUN
    step(1'b1, 9, 0, 1'b1);
    run_phase(0, 8, 6);
    check("t5_clr_fault", 32'(fault), 32'd0);
    check("t5_clr_lamp", 32'({lamp_g, lamp_y, lamp_r}), 32'b100);

    // Bad sequence, then a later illegal encoding must not overwrite the code
    step(1'b1, 10, 2, 1'b0);
    step(1'b1, 9, 2, 1'b0);
    step(1'b1, 8, 5, 1'b0);
    step(1'b1, 7, 0, 1'b0);
    step(1'b1, 6, 0, 1'b0);
    check("t3_code", 32'(fault_code), 32'd2);

    // Count skip in yellow
    step(1'b1, 5, 1, 1'b1);
    step(1'b1, 4, 1, 1'b0);
    step(1'b1, 2, 1, 1'b0);
    step(1'b1, 1, 1, 1'b0);
    step(1'b1, 0, 1, 1'b0);
    check("t4_skip", 32'(fault_code), 32'd3);

    // Yellow timeout: six samples fine, a seventh in the same phase faults
    step(1'b1, 5, 1, 1'b1);
    run_phase(1, 5, 0);
    step(1'b1, 15, 1, 1'b0);
    check("t4_before_to", 32'(fault), 32'd0);
    step(1'b1, 14, 1, 1'b0);
    step(1'b1, 13, 1, 1'b0);
    check("t4_timeout", 32'(fault_code), 32'd3);

    // Clear racing an illegal encoding
    step(1'b1, 0, 7, 1'b1);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    check("t5_race", 32'({fault, fault_code}), 32'b101);

    // Reset mid-red after three completed cycles
    step(1'b1, 15, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_phase(0, 15, 0);
      run_phase(1, 5, 0);
      run_phase(2, 10, (k == 2) ? 6 : 0);
    end
    check("t6_cycle", 32'(cycle_cnt), 32'd3);
    check("t6_red", 32'({lamp_g, lamp_y, lamp_r}), 32'b001);
    step(1'b0, 5, 2, 1'b0);
    check("t6_rst", 32'({fault, fault_code, lamp_g, lamp_y, lamp_r, cycle_cnt}), 32'd0);
    check("t6_rst_segs", 32'({seg_tens, seg_ones}), 32'h3FFF);
    step(1'b1, 4, 2, 1'b0);
    step(1'b1, 3, 2, 1'b0);
    check("t6_resume", 32'({lamp_r, seg_ones}), 32'({1'b1, 7'h19}));

    // Random controller traffic with corruption, clears and resets
    rph = 2;
    rc  = 2;
    for (int i = 0; i < 3000; i++) begin
      rcv  = rc;
      rgv  = rph;
      rsel = $urandom_range(999, 0);
      if (rsel < 15) rgv = $urandom_range(7, 0);
      else if (rsel < 30) rcv = $urandom_range(15, 0);
      rclr = ($urandom_range(99, 0) < 3);
      rrst = ($urandom_range(999, 0) >= 3);
      step(rrst, rcv, rgv, rclr);
      if (rc == 0 && $urandom_range(19, 0) != 0) begin
        rph = (rph + 1) % 3;
        rc  = $urandom_range(phase_limit(rph) - 1, 0);
      end else begin
        rc = (rc + 15) % 16;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
